// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, default byte width and the
// baud divider used by the transmitter and receiver.
package uart_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int CLK_PER_BIT = 217;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int GNT_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GNT_W-1:0]   ptr,
    output logic [GNT_W-1:0]   idx,
    output logic               any
);

    localparam int PW = GNT_W + 1;

    logic [PW-1:0] pos;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + PW'(k);
            if (pos >= PW'(NUM_REQ)) begin
                pos = pos - PW'(NUM_REQ);
            end
            if (req[pos[GNT_W-1:0]]) begin
                idx = pos[GNT_W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters, granting
// a whole packet (up to a byte flagged last) to one round-robin winner.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no owner; arbitrate among req_valid from rr_ptr upward
//   LOAD      | tx_start and req_ready[gnt_id] high, byte handed over
//   WAIT_ACK  | waiting for the transmitter to raise tx_busy
//   WAIT_DONE | frame on the line; waiting for tx_busy to fall
//   HOLD      | mid-packet; grant locked until the owner has another byte
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int GNT_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      gnt_valid,
    output logic [GNT_W-1:0]          gnt_id
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [GNT_W-1:0] rr_ptr;
    logic [GNT_W-1:0] pick_idx;
    logic [GNT_W-1:0] load_idx;
    logic [GNT_W-1:0] ptr_inc;
    logic             pick_any;
    logic             load_go;
    logic             pkt_end;
    logic             last_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GNT_W   (GNT_W)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign ptr_inc = (gnt_id == GNT_W'(NUM_REQ - 1)) ? '0 : gnt_id + GNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // load_go marks the edge into LOAD; the byte is captured on that edge so
    // tx_start, tx_data and req_ready are all registered and coincide in LOAD.
    always_comb begin
        state_nxt = state;
        load_go   = 1'b0;
        load_idx  = gnt_id;
        pkt_end   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_LOAD;
                    load_go   = 1'b1;
                    load_idx  = pick_idx;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        state_nxt = ST_IDLE;
                        pkt_end   = 1'b1;
                    end else begin
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (req_valid[gnt_id]) begin
                    state_nxt = ST_LOAD;
                    load_go   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            req_ready <= '0;
            last_q    <= 1'b0;
        end else begin
            tx_start  <= load_go;
            req_ready <= load_go ? (NUM_REQ'(1) << load_idx) : '0;
            if (load_go) begin
                gnt_id    <= load_idx;
                gnt_valid <= 1'b1;
                tx_data   <= req_data[load_idx*DATA_W +: DATA_W];
                last_q    <= req_last[load_idx];
            end
            if (pkt_end) begin
                gnt_valid <= 1'b0;
                rr_ptr    <= ptr_inc;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 4-requester instance walks through the
// packet scenarios, a 3-requester instance covers non-power-of-two wrap.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_last  = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy   = 1'b0;
    logic        gnt_valid;
    logic [1:0]  gnt_id;

    logic [2:0]  valid3 = '0;
    logic [23:0] data3  = '0;
    logic [2:0]  last3  = '0;
    logic [2:0]  ready3;
    logic        start3;
    logic [7:0]  txd3;
    logic        busy3  = 1'b0;
    logic        gv3;
    logic [1:0]  gid3;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8)) u4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .gnt_valid(gnt_valid), .gnt_id(gnt_id)
    );

    uart_tx_arbiter #(.NUM_REQ(3), .DATA_W(8)) u3 (
        .clk(clk), .rst(rst), .req_valid(valid3), .req_data(data3),
        .req_last(last3), .req_ready(ready3), .tx_start(start3),
        .tx_data(txd3), .tx_busy(busy3), .gnt_valid(gv3), .gnt_id(gid3)
    );

    // Transmitter models: busy rises ack_dly cycles after tx_start, lasts busy_len.
    int ack_dly  = 1;
    int busy_len = 10;
    int dly = 0, run = 0, dly3 = 0, run3 = 0;

    always @(posedge clk) begin
        if (tx_start) begin
            if (ack_dly <= 1) begin tx_busy <= 1'b1; run <= busy_len; end
            else dly <= ack_dly - 1;
        end else if (dly != 0) begin
            dly <= dly - 1;
            if (dly == 1) begin tx_busy <= 1'b1; run <= busy_len; end
        end else if (run != 0) begin
            run <= run - 1;
            if (run == 1) tx_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (start3) begin
            busy3 <= 1'b1;
            run3  <= busy_len;
        end else if (run3 != 0) begin
            run3 <= run3 - 1;
            if (run3 == 1) busy3 <= 1'b0;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Requester byte queues: {last, data}
    logic [8:0] mem [4][16];
    int head [4] = '{0, 0, 0, 0};
    int tail [4] = '{0, 0, 0, 0};
    logic [3:0] rdy_prev = '0;

    int cyc = 0;
    int log_cnt = 0;
    logic [7:0] log_data [32];
    logic [1:0] log_gnt  [32];
    int         log_cyc  [32];
    int log3_cnt = 0;
    logic [1:0] log3_gnt [32];
    int rdy_cnt [4] = '{0, 0, 0, 0};
    int viol_onehot = 0, viol_owner = 0, viol_hold = 0, viol_overlap = 0, viol_idx3 = 0;
    logic in_frame = 1'b0, seen_busy = 1'b0;
    logic [7:0] frame_data = '0;

    task automatic push(input int i, input logic last, input logic [7:0] d);
        mem[i][tail[i]] = {last, d};
        tail[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (head[i] != tail[i]) begin
                req_valid[i]        = 1'b1;
                req_data[i*8 +: 8]  = mem[i][head[i]][7:0];
                req_last[i]         = mem[i][head[i]][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*8 +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (tx_start) begin
            if (log_cnt < 32) begin
                log_data[log_cnt] = tx_data;
                log_gnt[log_cnt]  = gnt_id;
                log_cyc[log_cnt]  = cyc;
            end
            log_cnt++;
            if (in_frame) viol_overlap++;
            in_frame   = 1'b1;
            seen_busy  = 1'b0;
            frame_data = tx_data;
        end else if (in_frame) begin
            if (tx_data !== frame_data) viol_hold++;
            if (tx_busy) seen_busy = 1'b1;
            else if (seen_busy) in_frame = 1'b0;
        end
        if ($countones(req_ready) > 1) viol_onehot++;
        if (req_ready != 4'b0000 && (!gnt_valid || req_ready != (4'b0001 << gnt_id))) viol_owner++;
        for (int i = 0; i < 4; i++) if (req_ready[i]) rdy_cnt[i]++;
        if (start3) begin
            if (log3_cnt < 32) log3_gnt[log3_cnt] = gid3;
            log3_cnt++;
        end
        if (gid3 == 2'd3) viol_idx3++;
        for (int i = 0; i < 4; i++) if (rdy_prev[i] && head[i] != tail[i]) head[i]++;
        rdy_prev = req_ready;
        drive();
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int n = 0;
        while (log_cnt < target && n < budget) begin tick(); n++; end
        check(tag, 32'(log_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((gnt_valid || u4.state != ST_IDLE) && n < budget) begin tick(); n++; end
        check(tag, 32'(u4.state == ST_IDLE), 32'd1);
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        check("rst_tx_start",  32'(tx_start),  32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_gnt_id",    32'(gnt_id),    32'd0);
        check("rst_tx_data",   32'(tx_data),   32'd0);
        check("rst_rr_ptr",    32'(u4.rr_ptr), 32'd0);
        rst = 1'b0;

        // Contention: requesters 0 and 1 together, single-byte packets
        push(0, 1'b1, 8'h10);
        push(1, 1'b1, 8'h20);
        tick();
        tick();
        check("cont_first_start", 32'(tx_start),  32'd1);
        check("cont_first_gnt",   32'(gnt_id),    32'd0);
        check("cont_first_ready", 32'(req_ready), 32'h1);
        check("cont_first_data",  32'(tx_data),   32'h10);
        wait_starts(2, 40, "cont_second_timeout");
        check("cont_second_gnt",  32'(log_gnt[1]),  32'd1);
        check("cont_second_data", 32'(log_data[1]), 32'h20);
        check("cont_pkt_gap",     32'(log_cyc[1] - log_cyc[0]), 32'd13);
        wait_idle(40, "cont_idle_timeout");
        check("cont_rr_ptr", 32'(u4.rr_ptr), 32'd2);
        push(0, 1'b1, 8'h11);
        push(1, 1'b1, 8'h21);
        wait_starts(4, 60, "cont2_timeout");
        check("cont2_first_gnt",  32'(log_gnt[2]), 32'd0);
        check("cont2_second_gnt", 32'(log_gnt[3]), 32'd1);
        wait_idle(40, "cont2_idle_timeout");

        // Single requester, two-byte packet
        push(2, 1'b0, 8'h41);
        push(2, 1'b1, 8'h42);
        wait_starts(6, 60, "single_timeout");
        check("single_data0", 32'(log_data[4]), 32'h41);
        check("single_data1", 32'(log_data[5]), 32'h42);
        check("single_gnt1",  32'(log_gnt[5]),  32'd2);
        check("single_gap",   32'(log_cyc[5] - log_cyc[4]), 32'd13);
        wait_idle(40, "single_idle_timeout");
        check("single_ready_cnt", 32'(rdy_cnt[2]), 32'd2);
        check("single_gnt_valid", 32'(gnt_valid),  32'd0);
        check("single_rr_ptr",    32'(u4.rr_ptr),  32'd3);

        // Packet lock: owner 1 stalls while requester 3 waits
        push(1, 1'b0, 8'h51);
        wait_starts(7, 10, "lock_start_timeout");
        check("lock_first_gnt", 32'(log_gnt[6]), 32'd1);
        push(3, 1'b1, 8'h71);
        repeat (60) tick();
        check("lock_no_start", 32'(log_cnt),   32'd7);
        check("lock_gnt_id",   32'(gnt_id),    32'd1);
        check("lock_gnt_valid",32'(gnt_valid), 32'd1);
        check("lock_state",    32'(u4.state),  32'(ST_HOLD));
        push(1, 1'b1, 8'h52);
        wait_starts(8, 10, "lock_resume_timeout");
        check("lock_resume_gnt",  32'(log_gnt[7]),  32'd1);
        check("lock_resume_data", 32'(log_data[7]), 32'h52);
        wait_starts(9, 40, "lock_next_timeout");
        check("lock_next_gnt",  32'(log_gnt[8]),  32'd3);
        check("lock_next_data", 32'(log_data[8]), 32'h71);
        wait_idle(40, "lock_idle_timeout");
        check("wrap_rr_ptr_4", 32'(u4.rr_ptr), 32'd0);

        // Transmitter that raises busy three cycles after start
        ack_dly = 3;
        push(0, 1'b0, 8'h61);
        push(0, 1'b1, 8'h62);
        wait_starts(11, 80, "dly_timeout");
        check("dly_data0", 32'(log_data[9]),  32'h61);
        check("dly_data1", 32'(log_data[10]), 32'h62);
        check("dly_gap",   32'(log_cyc[10] - log_cyc[9]), 32'd15);
        wait_idle(40, "dly_idle_timeout");
        check("dly_data_hold",  32'(viol_hold),    32'd0);
        check("dly_no_overlap", 32'(viol_overlap), 32'd0);
        ack_dly = 1;

        // Reset while in WAIT_DONE
        push(3, 1'b0, 8'h81);
        push(3, 1'b1, 8'h82);
        wait_starts(12, 10, "rstmid_start_timeout");
        repeat (4) tick();
        check("rstmid_pre_state", 32'(u4.state), 32'(ST_WAIT_DONE));
        rst = 1'b1;
        head[3] = tail[3];
        rdy_prev = '0;
        tick();
        check("rstmid_gnt_valid", 32'(gnt_valid), 32'd0);
        check("rstmid_tx_start",  32'(tx_start),  32'd0);
        check("rstmid_req_ready", 32'(req_ready), 32'd0);
        check("rstmid_rr_ptr",    32'(u4.rr_ptr), 32'd0);
        rst = 1'b0;
        begin
            int n = 0;
            while (tx_busy && n < 20) begin tick(); n++; end
            check("rstmid_busy_drain", 32'(tx_busy), 32'd0);
        end
        push(2, 1'b1, 8'h91);
        wait_starts(13, 10, "rstmid_fresh_timeout");
        check("rstmid_fresh_gnt",  32'(log_gnt[12]),  32'd2);
        check("rstmid_fresh_data", 32'(log_data[12]), 32'h91);
        wait_idle(40, "rstmid_idle_timeout");
        check("rstmid_rr_ptr_end", 32'(u4.rr_ptr), 32'd3);

        // Three requesters, all continuously valid
        data3  = {8'hC0, 8'hB0, 8'hA0};
        last3  = 3'b111;
        valid3 = 3'b111;
        begin
            int n = 0;
            while (log3_cnt < 5 && n < 150) begin tick(); n++; end
            check("wrap3_timeout", 32'(log3_cnt >= 5), 32'd1);
        end
        check("wrap3_gnt0", 32'(log3_gnt[0]), 32'd0);
        check("wrap3_gnt1", 32'(log3_gnt[1]), 32'd1);
        check("wrap3_gnt2", 32'(log3_gnt[2]), 32'd2);
        check("wrap3_gnt3", 32'(log3_gnt[3]), 32'd0);
        check("wrap3_gnt4", 32'(log3_gnt[4]), 32'd1);
        check("wrap3_no_idx3", 32'(viol_idx3), 32'd0);

        check("ready_onehot", 32'(viol_onehot), 32'd0);
        check("ready_owner",  32'(viol_owner),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
